mem_arbiter2: RTL and testbench

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

---
 rtl/mem_arbiter2.sv | 97 +++++++++
 tb/tb_mem_arbiter2.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// Two-master arbiter in front of a single-port synchronous memory; one access per 3 cycles.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default is fixed priority, master 0 first).
module mem_arbiter2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_wmask,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_wmask,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wmask;
  } memReq_t;

  state_t  state, stateNext;
  memReq_t lat;
  logic    winner;
  logic    grantNow;
  logic    pick;

  assign grantNow = (state == IDLE) && (m0_req || m1_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prio names the master that wins a tie; it flips away from each winner
  logic prio;
  assign pick = (m0_req && m1_req) ? prio : m1_req;

  always_ff @(posedge clk) begin
    if (reset)         prio <= 1'b0;
    else if (grantNow) prio <= !pick;
  end
`else
  assign pick = !m0_req;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantNow) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lat    <= '0;
      winner <= 1'b0;
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= stateNext;
      m0_gnt <= grantNow && !pick;
      m1_gnt <= grantNow && pick;
      // memory read data lands during RESP, so ack and rdata go out together next cycle
      m0_ack <= (state == RESP) && !winner;
      m1_ack <= (state == RESP) && winner;
      if (state == RESP) rdata <= mem_rdata;
      if (grantNow) begin
        winner <= pick;
        lat    <= pick ? {m1_addr, m1_wdata, m1_we, m1_wmask}
                       : {m0_addr, m0_wdata, m0_we, m0_wmask};
      end
    end
  end

  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign mem_we    = (state == ACCESS) && lat.we;
  assign mem_wmask = mem_we ? lat.wmask : 4'b0000;
endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: directed vector table, hand sequences, then random traffic vs a transaction model.
module tb_mem_arbiter2;
  localparam bit RR =
`ifdef MEM_ARB_ROUND_ROBIN_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;

  int nVec = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  mem_arbiter2 dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_wmask(m0_wmask),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_wmask(m1_wmask),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] initVal(input int i);
    return (i == 64) ? 32'hDEADBEEF : ((i * 32'h01010101) ^ 32'hA5000000);
  endfunction

  // single-port synchronous memory: registered read, byte-masked write
  logic [31:0] memArr [256];
  logic        memClr;
  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 256; i++) memArr[i] <= initVal(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) memArr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= memArr[mem_addr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, r0, r1;
    logic [1:0]  g, a;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr, wd;
    bit          chkRd;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit rst, r0, r1, input logic [1:0] g, a, input logic we,
                      input logic [3:0] mask, input logic [31:0] addr, wd,
                      input bit chkRd, input logic [31:0] rd);
    tbl.push_back('{rst, r0, r1, g, a, we, mask, addr, wd, chkRd, rd});
  endtask

  task automatic idle(input int n);
    m0_req = 0; m1_req = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // transaction-level reference: each access owns the memory for 3 edges
  logic [31:0] shadow [256];
  int          n, busyUntil, ackDue;
  bit          ackWho, ackRead, prio, w;
  logic [31:0] ackData, lastAddr, lastWdata, eRd, aA, aW;
  logic [1:0]  eG, eA;
  logic        eWe, aWe;
  logic [3:0]  eMask, aM;
  bit          chkRd;

  task automatic modelEdge();
    n++;
    eG = 2'b00; eA = 2'b00; eWe = 0; eMask = 4'h0; chkRd = 0;
    if (reset) begin
      busyUntil = n + 1; ackDue = -1; prio = 0;
      lastAddr = 0; lastWdata = 0; chkRd = 1; eRd = 0;
    end else begin
      if (ackDue == n) begin
        eA[ackWho] = 1'b1;
        if (ackRead) begin chkRd = 1; eRd = ackData; end
      end
      if (n >= busyUntil && (m0_req || m1_req)) begin
        w = (m0_req && m1_req) ? (RR ? prio : 1'b0) : m1_req;
        aA = w ? m1_addr : m0_addr; aW = w ? m1_wdata : m0_wdata;
        aWe = w ? m1_we : m0_we;    aM = w ? m1_wmask : m0_wmask;
        eG[w] = 1'b1;
        lastAddr = aA; lastWdata = aW;
        eWe = aWe; eMask = aWe ? aM : 4'h0;
        ackRead = !aWe; ackData = shadow[aA[9:2]];
        if (aWe)
          for (int b = 0; b < 4; b++)
            if (aM[b]) shadow[aA[9:2]][8*b +: 8] = aW[8*b +: 8];
        ackWho = w; ackDue = n + 2; busyUntil = n + 3; prio = !w;
      end
    end
  endtask

  localparam logic [31:0] A0 = 32'h100, A1 = 32'h20, W1 = 32'h12345678, D = 32'hDEADBEEF;

  initial begin
    int gCount, lastG;
    reset = 1; memClr = 1;
    m0_req = 0; m1_req = 0;
    m0_addr = A0; m0_wdata = 0; m0_we = 0; m0_wmask = 4'hF;
    m1_addr = A1; m1_wdata = W1; m1_we = 1; m1_wmask = 4'b0011;
    @(posedge clk); #1;
    memClr = 0;

    // rst r0 r1  gnt    ack   we   mask  addr wdata chkRd rdata
    addv(1, 1, 1, 2'b00, 2'b00, 0, 4'h0, 0,  0,  1, 0);
    addv(0, 1, 0, 2'b01, 2'b00, 0, 4'h0, A0, 0,  0, 0);
    addv(0, 0, 0, 2'b00, 2'b00, 0, 4'h0, A0, 0,  0, 0);
    addv(0, 0, 0, 2'b00, 2'b01, 0, 4'h0, A0, 0,  1, D);
    addv(0, 0, 1, 2'b10, 2'b00, 1, 4'h3, A1, W1, 0, 0);
    addv(0, 0, 0, 2'b00, 2'b00, 0, 4'h0, A1, W1, 0, 0);
    addv(0, 0, 0, 2'b00, 2'b10, 0, 4'h0, A1, W1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      addv(0, 1, 1, 2'b01, 2'b00, 0, 4'h0, A0, 0, 0, 0);
      addv(0, 1, 1, 2'b00, 2'b00, 0, 4'h0, A0, 0, 0, 0);
      addv(0, 1, 1, 2'b00, 2'b01, 0, 4'h0, A0, 0, 1, D);
      addv(0, 1, 1, RR ? 2'b10 : 2'b01, 2'b00, RR, RR ? 4'h3 : 4'h0, RR ? A1 : A0, RR ? W1 : 0, 0, 0);
      addv(0, 1, 1, 2'b00, 2'b00, 0, 4'h0, RR ? A1 : A0, RR ? W1 : 0, 0, 0);
      addv(0, 1, 1, 2'b00, RR ? 2'b10 : 2'b01, 0, 4'h0, RR ? A1 : A0, RR ? W1 : 0, !RR, D);
    end
    foreach (tbl[i]) begin
      reset = tbl[i].rst; m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      @(posedge clk); #1;
      chk("tbl_gnt", {m1_gnt, m0_gnt}, tbl[i].g);
      chk("tbl_ack", {m1_ack, m0_ack}, tbl[i].a);
      chk("tbl_mem_we", mem_we, tbl[i].we);
      chk("tbl_mem_wmask", mem_wmask, tbl[i].mask);
      chk("tbl_mem_addr", mem_addr, tbl[i].addr);
      chk("tbl_mem_wdata", mem_wdata, tbl[i].wd);
      if (tbl[i].chkRd) chk("tbl_rdata", rdata, tbl[i].rd);
    end
    idle(3);

    // reset lands during ACCESS of an m0 write: no ack, no write strobe, m0 still first afterwards
    m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hCAFEF00D;
    m0_req = 1;
    @(posedge clk); #1;
    chk("abort_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("abort_we_access", mem_we, 1'b1);
    m0_req = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_we_after", mem_we, 1'b0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_ack0", {m1_ack, m0_ack}, 2'b00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_noack", {m1_ack, m0_ack}, 2'b00);
      chk("abort_nowe", mem_we, 1'b0);
    end
    m0_we = 0; m0_addr = A0; m0_req = 1; m1_req = 1;
    @(posedge clk); #1;
    chk("abort_next_gnt", {m1_gnt, m0_gnt}, 2'b01);
    idle(3);

    // a lone requester is served back to back every 3 cycles
    gCount = 0; lastG = -1;
    m1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk("solo_m0_gnt", m0_gnt, 1'b0);
      if (m1_gnt) begin
        if (lastG >= 0) chk("solo_spacing", c - lastG, 3);
        lastG = c; gCount++;
      end
    end
    chk("solo_count", gCount, 4);
    idle(3);

    // random traffic against the transaction model
    n = 0;
    reset = 1; memClr = 1;
    for (int i = 0; i < 256; i++) shadow[i] = initVal(i);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      memClr = 0;
      chk("rnd_gnt", {m1_gnt, m0_gnt}, eG);
      chk("rnd_ack", {m1_ack, m0_ack}, eA);
      chk("rnd_mem_we", mem_we, eWe);
      chk("rnd_mem_wmask", mem_wmask, eMask);
      chk("rnd_mem_addr", mem_addr, lastAddr);
      chk("rnd_mem_wdata", mem_wdata, lastWdata);
      if (chkRd) chk("rnd_rdata", rdata, eRd);
      reset    = ($urandom_range(0, 79) == 0);
      m0_req   = ($urandom_range(0, 2) != 0);
      m1_req   = ($urandom_range(0, 2) != 0);
      m0_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      m1_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_we    = 1'($urandom); m1_we = 1'($urandom);
      m0_wmask = 4'($urandom); m1_wmask = 4'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
